// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, opcode constants and FSM encoding
// for the iterative signed multiply/divide unit.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration. Its adder is the only
// iteration adder in the unit; the divider reuses o_sum.
module booth_step
    import muldiv_pkg::*;
#(
    parameter int W = MD_WIDTH
) (
    input  logic [2*W:0] i_acc,
    input  logic [W:0]   i_mcand,
    input  logic [1:0]   i_pair,
    output logic [W:0]   o_sum,
    output logic [2*W:0] o_acc,
    output logic         o_qm1
);

    logic [W:0] w_opnd;
    logic       w_sub;

    always_comb begin
        w_opnd = '0;
        w_sub  = 1'b0;
        case (i_pair)
            2'b10: begin
                w_opnd = ~i_mcand;
                w_sub  = 1'b1;
            end
            2'b01: w_opnd = i_mcand;
            default: ;
        endcase
    end

    assign o_sum = i_acc[2*W:W] + w_opnd + {{W{1'b0}}, w_sub};
    assign o_acc = {o_sum[W], o_sum, i_acc[W-1:1]};
    assign o_qm1 = i_acc[0];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative signed multiply (Booth) and divide
// (non-restoring) sharing one accumulator and one adder.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2*WIDTH:0] r_acc;
    logic             r_qm1;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_in_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [2*WIDTH:0] w_div_pre;
    logic [2*WIDTH:0] w_bs_acc;
    logic [WIDTH:0]   w_bs_mcand;
    logic [1:0]       w_bs_pair;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH:0] w_booth_acc;
    logic             w_bs_qm1;
    logic [2*WIDTH:0] w_div_nx;
    logic [2*WIDTH:0] w_step;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_rmag;
    logic [WIDTH-1:0] w_qs;
    logic [WIDTH-1:0] w_rs;
    logic [WIDTH-1:0] w_fin_hi;
    logic [WIDTH-1:0] w_fin_lo;
    logic             w_bzero;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Start is refused while the done pulse is still showing.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !r_done) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_last     = 1'b1;
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_in_amag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign w_bmag    = r_b[WIDTH-1] ? (~r_b + WIDTH'(1)) : r_b;
    assign w_bzero   = (r_b == '0);
    assign w_div_pre = {r_acc[2*WIDTH-1:0], 1'b0};

    // Divide: remainder r_acc[2W:W] sign picks subtract or add.
    always_comb begin
        if (r_op == OP_MUL) begin
            w_bs_acc   = r_acc;
            w_bs_mcand = {r_a[WIDTH-1], r_a};
            w_bs_pair  = {r_acc[0], r_qm1};
        end else begin
            w_bs_acc   = w_div_pre;
            w_bs_mcand = {1'b0, w_bmag};
            w_bs_pair  = r_acc[2*WIDTH] ? 2'b01 : 2'b10;
        end
    end

    booth_step #(
        .W (WIDTH)
    ) u_step (
        .i_acc   (w_bs_acc),
        .i_mcand (w_bs_mcand),
        .i_pair  (w_bs_pair),
        .o_sum   (w_sum),
        .o_acc   (w_booth_acc),
        .o_qm1   (w_bs_qm1)
    );

    assign w_div_nx = {w_sum, w_div_pre[WIDTH-1:1], ~w_sum[WIDTH]};
    assign w_step   = (r_op == OP_MUL) ? w_booth_acc : w_div_nx;

    assign w_q    = w_div_nx[WIDTH-1:0];
    assign w_rmag = w_sum[WIDTH] ? (w_sum[WIDTH-1:0] + w_bmag)
                                 : w_sum[WIDTH-1:0];
    assign w_qs   = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (~w_q + WIDTH'(1))
                                                   : w_q;
    assign w_rs   = r_a[WIDTH-1] ? (~w_rmag + WIDTH'(1)) : w_rmag;

    always_comb begin
        w_fin_hi = w_step[2*WIDTH-1:WIDTH];
        w_fin_lo = w_step[WIDTH-1:0];
        if (r_op == OP_DIV) begin
            if (w_bzero) begin
                w_fin_hi = r_a;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = w_rs;
                w_fin_lo = w_qs;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt  <= '0;
            r_op   <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_qm1  <= 1'b0;
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op   <= op;
                r_a    <= a;
                r_b    <= b;
                r_cnt  <= '0;
                r_qm1  <= 1'b0;
                r_div0 <= 1'b0;
                r_acc  <= {{(WIDTH+1){1'b0}},
                           (op == OP_DIV) ? w_in_amag : b};
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + CW'(1);
                r_qm1 <= w_bs_qm1;
                if (w_last) begin
                    r_acc <= {w_fin_hi[WIDTH-1], w_fin_hi, w_fin_lo};
                end else begin
                    r_acc <= w_step;
                end
            end else if (r_state == ST_DONE) begin
                r_hi   <= r_acc[2*WIDTH-1:WIDTH];
                r_lo   <= r_acc[WIDTH-1:0];
                r_done <= 1'b1;
                r_div0 <= (r_op == OP_DIV) && w_bzero;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign div0 = r_div0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table vectors, hand corner sequences and random
// operations checked against a plain-arithmetic reference.
module tb_muldiv_ctrl;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div0;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } vec_t;

    vec_t tbl[14];

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {div0, hi, lo} from plain signed arithmetic
    function automatic logic [64:0] model(input logic iop,
                                          input logic [31:0] ia,
                                          input logic [31:0] ib);
        int     sa;
        int     sb;
        int     q;
        int     r;
        longint p;
        sa = int'(ia);
        sb = int'(ib);
        if (iop == 1'b0) begin
            p = longint'(sa) * longint'(sb);
            return {1'b0, p};
        end
        if (ib == 32'd0)
            return {1'b1, ia, 32'hFFFF_FFFF};
        if (ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF)
            return {1'b0, 32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r, q};
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            5: return 32'hFFFF_FFFF - 32'($urandom_range(0, 14));
            default: return $urandom;
        endcase
    endfunction

    // Caller is at a negedge with done low; returns at the done negedge.
    task automatic run_op(input logic iop, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] eh,
                          input logic [31:0] el, input logic ed,
                          input int poke, input string nm);
        int          edges;
        logic        seen;
        logic        busy_ok;
        logic        hold_ok;
        logic        clr_ok;
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        op = iop;
        a = ia;
        b = ib;
        start = 1'b1;
        edges = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        clr_ok = 1'b1;
        while (!seen && edges < 100) begin
            @(negedge clk);
            edges++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
                if (edges == 1 && div0 !== 1'b0) clr_ok = 1'b0;
            end
            op = 1'($urandom);
            a = $urandom;
            b = $urandom;
            start = (edges == poke);
        end
        start = 1'b0;
        check({nm, "_done"}, 64'(seen), 64'd1);
        check({nm, "_lat"}, 64'(edges), 64'(LAT));
        check({nm, "_hi"}, 64'(hi), 64'(eh));
        check({nm, "_lo"}, 64'(lo), 64'(el));
        check({nm, "_div0"}, 64'(div0), 64'(ed));
        check({nm, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({nm, "_busy_idle"}, 64'(busy), 64'd0);
        check({nm, "_hold"}, 64'(hold_ok), 64'd1);
        check({nm, "_div0_clr"}, 64'(clr_ok), 64'd1);
    endtask

    initial begin
        logic        quiet;
        logic [64:0] m;
        logic        rop;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0]  = '{1'b0, 32'hFFFF_FFFB, 32'h0000_0007,
                    32'hFFFF_FFFF, 32'hFFFF_FFDD, 1'b0};
        tbl[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000,
                    32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[2]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0064, 32'h0000_0000,
                    32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        tbl[5]  = '{1'b0, 32'h0000_0003, 32'h0000_0004,
                    32'h0000_0000, 32'h0000_000C, 1'b0};
        tbl[6]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                    32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
        tbl[7]  = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF,
                    32'hC000_0000, 32'h8000_0000, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE,
                    32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0005, 32'h0000_0007,
                    32'h0000_0005, 32'h0000_0000, 1'b0};
        tbl[10] = '{1'b1, 32'h8000_0000, 32'h8000_0000,
                    32'h0000_0000, 32'h0000_0001, 1'b0};
        tbl[11] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000,
                    32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[12] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        tbl[13] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'h0000_0000, 32'h0000_0001, 1'b0};

        // asynchronous reset, before any clock edge
        #2 clr = 1'b1;
        #1;
        check("rst_ctl", 64'({busy, done, div0}), 64'd0);
        check("rst_data", {hi, lo}, 64'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hold_ctl", 64'({busy, done, div0}), 64'd0);
        check("rst_hold_data", {hi, lo}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (i != 0) begin
                @(negedge clk);
                check("done_pulse", 64'(done), 64'd0);
            end
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi,
                   tbl[i].lo, tbl[i].d0, 0, $sformatf("vec%0d", i));
        end

        // start while done is showing must be dropped
        op = 1'b0;
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        quiet = !busy && !done;
        repeat (5) begin
            @(negedge clk);
            if (busy || done) quiet = 1'b0;
        end
        check("start_in_done", 64'(quiet), 64'd1);

        // second start mid-run is neither applied nor queued
        m = model(1'b0, 32'h0001_2345, 32'h0000_0321);
        run_op(1'b0, 32'h0001_2345, 32'h0000_0321, m[63:32], m[31:0],
               m[64], 5, "poke");
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy || done) quiet = 1'b0;
        end
        check("poke_single", 64'(quiet), 64'd1);

        // clr in the middle of a divide
        op = 1'b1;
        a = 32'd1000;
        b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("abort_ctl", 64'({busy, done, div0}), 64'd0);
        check("abort_data", {hi, lo}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy || done) quiet = 1'b0;
        end
        check("abort_quiet", 64'(quiet), 64'd1);
        run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0, "abort_mul");

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("done_pulse", 64'(done), 64'd0);
            rop = 1'($urandom);
            ra = rand_opnd();
            rb = rand_opnd();
            m = model(rop, ra, rb);
            run_op(rop, ra, rb, m[63:32], m[31:0], m[64], 0,
                   $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
